rr_arb8: RTL and testbench

Round-robin arbiter that shares one multi-cycle resource (a functional unit or bus port) among `N` requesters. Its priority order matches the team's priority selectors: higher index wins, but the order rotates after every grant. A grant is held as a tenure and ends on a `done` handshake, on requester abandonment, or on a hold-time limit. The block sits between issue logic and the shared unit and drives that unit's select.

---
 rtl/rr_arb8.sv | 121 ++++++++++++
 tb/tb_rr_arb8.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
// Round-robin arbiter for one multi-cycle shared resource: higher index wins,
// rotation follows the last winner, tenure ends on done, abandon or hold limit.
module rr_arb8 #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int IW = $clog2(N);
    localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '1 : CW'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    state_e          state_q;
    logic [N-1:0]    gnt_q;
    logic [IW-1:0]   gnt_idx_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   hold_cnt_q;
    logic            timeout_q;

    logic [IW-1:0]   pick_cand;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic [N-1:0]    pick_onehot;
    logic            lim_hit;
    logic            abandon;
    logic            release_now;
    logic            grant_now;

    // Scan from (last-1) downwards with wrap; last itself is visited last.
    always_comb begin
        pick_cand = '0;
        pick_idx  = '0;
        pick_vld  = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            pick_cand = last_q - IW'(k);
            if (!pick_vld && req[pick_cand]) begin
                pick_vld = 1'b1;
                pick_idx = pick_cand;
            end
        end
    end

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = pick_vld;
    end

    always_comb begin
        lim_hit     = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        abandon     = !req[gnt_idx_q];
        release_now = done || abandon || lim_hit;
        grant_now   = en && pick_vld;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            last_q     <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_now) begin
                        state_q    <= ST_HOLD;
                        gnt_q      <= pick_onehot;
                        gnt_idx_q  <= pick_idx;
                        last_q     <= pick_idx;
                        hold_cnt_q <= '0;
                    end
                end
                ST_HOLD: begin
                    if (release_now) begin
                        // A forced release is flagged only when nothing else ended the tenure.
                        timeout_q <= lim_hit && !done && !abandon;
                        if (grant_now) begin
                            gnt_q      <= pick_onehot;
                            gnt_idx_q  <= pick_idx;
                            last_q     <= pick_idx;
                            hold_cnt_q <= '0;
                        end else begin
                            state_q    <= ST_IDLE;
                            gnt_q      <= '0;
                            gnt_idx_q  <= '0;
                            hold_cnt_q <= '0;
                        end
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Bench for rr_arb8: an unlimited-hold and a MAX_HOLD=4 instance share stimulus
// and are compared every cycle against a tenure-level model of the arbitration rules.
module tb_rr_arb8;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic [7:0] req;
    logic       done;

    logic [7:0] nl_gnt, lm_gnt;
    logic [2:0] nl_idx, lm_idx;
    logic       nl_vld, lm_vld;
    logic       nl_to, lm_to;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: holder (-1 idle), last winner, cycles held so far.
    int m_hold[2];
    int m_last[2];
    int m_cnt[2];
    bit m_to[2];
    int m_max[2] = '{0, 4};

    rr_arb8 #(.N(8), .MAX_HOLD(0)) u_nolim (
        .clock(clock), .reset_n(reset_n), .en(en), .req(req), .done(done),
        .gnt(nl_gnt), .gnt_idx(nl_idx), .gnt_valid(nl_vld), .timeout(nl_to)
    );

    rr_arb8 #(.N(8), .MAX_HOLD(4)) u_lim (
        .clock(clock), .reset_n(reset_n), .en(en), .req(req), .done(done),
        .gnt(lm_gnt), .gnt_idx(lm_idx), .gnt_valid(lm_vld), .timeout(lm_to)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int last, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (last - k + 16) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input int m);
        int  p;
        bit  lim;
        bit  ab;
        if (!reset_n) begin
            m_hold[m] = -1; m_last[m] = 0; m_cnt[m] = 0; m_to[m] = 0;
            return;
        end
        m_to[m] = 0;
        p = pick(m_last[m], req);
        if (m_hold[m] < 0) begin
            if (en && p >= 0) begin
                m_hold[m] = p; m_last[m] = p; m_cnt[m] = 0;
            end
        end else begin
            lim = (m_max[m] != 0) && (m_cnt[m] + 1 == m_max[m]);
            ab  = !req[m_hold[m]];
            if (done || ab || lim) begin
                m_to[m] = lim && !done && !ab;
                if (en && p >= 0) begin
                    m_hold[m] = p; m_last[m] = p; m_cnt[m] = 0;
                end else begin
                    m_hold[m] = -1; m_cnt[m] = 0;
                end
            end else begin
                m_cnt[m]++;
            end
        end
    endtask

    function automatic logic [31:0] exp_gnt(input int m);
        return (m_hold[m] >= 0) ? (32'd1 << m_hold[m]) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_idx(input int m);
        return (m_hold[m] >= 0) ? 32'(m_hold[m]) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        check("nl.gnt", {24'd0, nl_gnt}, exp_gnt(0));
        check("nl.idx", {29'd0, nl_idx}, exp_idx(0));
        check("nl.vld", {31'd0, nl_vld}, {31'd0, m_hold[0] >= 0});
        check("nl.to",  {31'd0, nl_to},  {31'd0, m_to[0]});
        check("lm.gnt", {24'd0, lm_gnt}, exp_gnt(1));
        check("lm.idx", {29'd0, lm_idx}, exp_idx(1));
        check("lm.vld", {31'd0, lm_vld}, {31'd0, m_hold[1] >= 0});
        check("lm.to",  {31'd0, lm_to},  {31'd0, m_to[1]});
    endtask

    task automatic do_reset();
        reset_n = 1'b0; done = 1'b0; req = '0; en = 1'b1;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        int seen[8];

        reset_n = 1'b0; en = 1'b1; req = '0; done = 1'b0;
        m_hold = '{-1, -1}; m_last = '{0, 0}; m_cnt = '{0, 0}; m_to = '{0, 0};
        step();
        step();
        check("rst.gnt", {24'd0, nl_gnt}, 32'h0);
        check("rst.idx", {29'd0, nl_idx}, 32'h0);
        check("rst.vld", {31'd0, nl_vld}, 32'h0);
        check("rst.to",  {31'd0, lm_to},  32'h0);
        reset_n = 1'b1;

        // Basic grant and handoff
        req = 8'h81;
        step();
        check("basic.gnt0", {24'd0, nl_gnt}, 32'h80);
        check("basic.idx0", {29'd0, nl_idx}, 32'd7);
        done = 1'b1;
        step();
        check("basic.gnt1", {24'd0, nl_gnt}, 32'h01);
        check("basic.idx1", {29'd0, nl_idx}, 32'd0);
        done = 1'b0;
        step();
        check("basic.hold", {24'd0, nl_gnt}, 32'h01);
        done = 1'b1;
        step();
        check("basic.gnt2", {24'd0, nl_gnt}, 32'h80);
        done = 1'b0;

        // Full rotation
        do_reset();
        req = 8'hFF; done = 1'b1;
        seen = '{default: 0};
        for (int i = 0; i < 9; i++) begin
            step();
            check("rot.idx", {29'd0, nl_idx}, 32'(exp_seq[i]));
            if (i < 8) seen[nl_idx]++;
        end
        for (int i = 0; i < 8; i++) check("rot.once", 32'(seen[i]), 32'd1);
        done = 1'b0;

        // Timeout on the MAX_HOLD=4 instance
        do_reset();
        req = 8'h24;
        step();
        check("to.gnt0", {24'd0, lm_gnt}, 32'h20);
        for (int i = 0; i < 3; i++) begin
            step();
            check("to.hold", {24'd0, lm_gnt}, 32'h20);
            check("to.none", {31'd0, lm_to}, 32'h0);
        end
        step();
        check("to.hand", {24'd0, lm_gnt}, 32'h04);
        check("to.pulse", {31'd0, lm_to}, 32'h1);
        req = 8'h04;
        for (int i = 0; i < 3; i++) begin
            step();
            check("to.sole", {24'd0, lm_gnt}, 32'h04);
            check("to.low", {31'd0, lm_to}, 32'h0);
        end
        step();
        check("to.regnt", {24'd0, lm_gnt}, 32'h04);
        check("to.pulse2", {31'd0, lm_to}, 32'h1);

        // Abandon and ignored done
        do_reset();
        req = 8'h08;
        step();
        check("ab.gnt", {24'd0, nl_gnt}, 32'h08);
        req = 8'h00;
        step();
        check("ab.rel", {24'd0, nl_gnt}, 32'h0);
        check("ab.vld", {31'd0, nl_vld}, 32'h0);
        done = 1'b1;
        step();
        check("ab.done", {24'd0, nl_gnt}, 32'h0);
        done = 1'b0;

        // en gating
        do_reset();
        en = 1'b0; req = 8'h10;
        step();
        step();
        check("en.off", {24'd0, nl_gnt}, 32'h0);
        en = 1'b1;
        step();
        check("en.on", {24'd0, nl_gnt}, 32'h10);
        en = 1'b0;
        step();
        check("en.keep", {24'd0, nl_gnt}, 32'h10);
        done = 1'b1;
        step();
        check("en.idle", {24'd0, nl_gnt}, 32'h0);
        done = 1'b0;
        step();
        check("en.stay", {24'd0, nl_gnt}, 32'h0);
        en = 1'b1;

        // Reset mid-tenure restores rotation
        do_reset();
        req = 8'h40;
        step();
        check("rm.gnt", {24'd0, nl_gnt}, 32'h40);
        reset_n = 1'b0;
        step();
        check("rm.gnt0", {24'd0, nl_gnt}, 32'h0);
        check("rm.idx0", {29'd0, nl_idx}, 32'h0);
        reset_n = 1'b1; req = 8'h41;
        step();
        check("rm.rot41", {24'd0, nl_gnt}, 32'h40);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; req = 8'hC0;
        step();
        check("rm.rotC0", {24'd0, nl_gnt}, 32'h80);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            en      = ($urandom_range(0, 7) != 0);
            done    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                req = 8'($urandom);
                if ($urandom_range(0, 1) != 0) req = req & 8'($urandom);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
